sdram_dq_ctrl: RTL and testbench



---
 rtl/sdram_dq_ctrl.sv | 156 +++++++++++++++
 tb/tb_sdram_dq_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_dq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sdram_dq_ctrl
// Description : Controller-side driver/capture logic for a bidirectional
//               SDRAM DQ bus. Runs one read or write burst at a time. Drives
//               DQ with output enable on writes. Tri-states DQ and captures
//               returned beats after the CAS latency on reads. Leaves a
//               turnaround gap after reads so that both ends never drive
//               DQ together.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_dq_ctrl #(
    parameter int DQ_WIDTH    = 16,
    parameter int CAS_LATENCY = 2,   // 1..3
    parameter int BURST_LEN   = 4,   // 1..8
    parameter int TURNAROUND  = 1    // 0..3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [DQ_WIDTH-1:0] wr_data,
    output logic                wr_ack,
    output logic [DQ_WIDTH-1:0] dq_out,
    output logic                dq_oe,
    input  logic [DQ_WIDTH-1:0] dq_in,
    output logic [DQ_WIDTH-1:0] rd_data,
    output logic                rd_valid,
    output logic                busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WRITE   = 3'd1,
        S_RD_WAIT = 3'd2,
        S_RD_CAP  = 3'd3,
        S_TURN    = 3'd4
    } state_t;

    // Terminal counter values for each multi-cycle state. The write count
    // already includes the beat taken in the accept cycle, so WRITE ends
    // when all BURST_LEN beats have been consumed.
    localparam logic [3:0] C_WR_LAST   = 4'(BURST_LEN);
    localparam logic [3:0] C_CAP_LAST  = 4'(BURST_LEN - 1);
    localparam logic [3:0] C_WAIT_LAST = 4'((CAS_LATENCY > 1) ? CAS_LATENCY - 2 : 0);
    localparam logic [3:0] C_TURN_LAST = 4'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  capture;
    logic                  dq_oe_q, dq_oe_d;
    logic [DQ_WIDTH-1:0]   dq_out_q, dq_out_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DQ_WIDTH-1:0]   rd_data_q, rd_data_d;

    // Next-state, beat counter, handshakes and data-path next values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_ready = 1'b0;
        wr_ack    = 1'b0;
        capture   = 1'b0;
        if (!reset) begin
            case (state_q)
                S_IDLE: begin
                    cmd_ready = 1'b1;
                    if (cmd_valid) begin
                        cnt_d = 4'd0;
                        if (cmd_write) begin
                            // First write beat is consumed in the accept cycle.
                            wr_ack  = 1'b1;
                            cnt_d   = 4'd1;
                            state_d = S_WRITE;
                        end else if (CAS_LATENCY > 1) begin
                            state_d = S_RD_WAIT;
                        end else begin
                            state_d = S_RD_CAP;
                        end
                    end
                end
                S_WRITE: begin
                    if (cnt_q == C_WR_LAST) begin
                        cnt_d   = 4'd0;
                        state_d = S_IDLE;
                    end else begin
                        wr_ack = 1'b1;
                        cnt_d  = cnt_q + 4'd1;
                    end
                end
                S_RD_WAIT: begin
                    if (cnt_q == C_WAIT_LAST) begin
                        cnt_d   = 4'd0;
                        state_d = S_RD_CAP;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                S_RD_CAP: begin
                    capture = 1'b1;
                    if (cnt_q == C_CAP_LAST) begin
                        cnt_d   = 4'd0;
                        state_d = (TURNAROUND > 0) ? S_TURN : S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                S_TURN: begin
                    if (cnt_q == C_TURN_LAST) begin
                        cnt_d   = 4'd0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                default: begin
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                end
            endcase
        end
        // A beat sampled this cycle is driven on the pad next cycle; the
        // pad value holds once the burst ends.
        dq_oe_d    = wr_ack;
        dq_out_d   = wr_ack ? wr_data : dq_out_q;
        rd_valid_d = capture;
        rd_data_d  = capture ? dq_in : rd_data_q;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            dq_oe_q    <= 1'b0;
            dq_out_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dq_oe_q    <= dq_oe_d;
            dq_out_q   <= dq_out_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign dq_oe    = dq_oe_q;
    assign dq_out   = dq_out_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign busy     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sdram_dq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_dq_ctrl
// Description : Self-checking bench for sdram_dq_ctrl. A timestamp-based
//               model (busy-until cycle, write-ack window, capture window)
//               predicts every output each cycle; literal checks pin the
//               model on the directed scenarios. A second instance covers
//               CAS_LATENCY=3, BURST_LEN=1, TURNAROUND=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_dq_ctrl;

    localparam int W  = 16;
    localparam int CL = 2;
    localparam int BL = 4;
    localparam int TA = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Main instance signals
    logic         reset, cmd_valid, cmd_write;
    logic [W-1:0] wr_data, dq_in;
    logic         cmd_ready, wr_ack, dq_oe, rd_valid, busy;
    logic [W-1:0] dq_out, rd_data;

    // Second instance signals
    logic         cmd_valid6;
    logic [W-1:0] dq_in6;
    logic         cmd_ready6, wr_ack6, dq_oe6, rd_valid6, busy6;
    logic [W-1:0] dq_out6, rd_data6;

    sdram_dq_ctrl #(.DQ_WIDTH(W), .CAS_LATENCY(CL), .BURST_LEN(BL), .TURNAROUND(TA)) u_dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .wr_data(wr_data), .wr_ack(wr_ack),
        .dq_out(dq_out), .dq_oe(dq_oe), .dq_in(dq_in),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy)
    );

    sdram_dq_ctrl #(.DQ_WIDTH(W), .CAS_LATENCY(3), .BURST_LEN(1), .TURNAROUND(0)) u_dut6 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid6), .cmd_ready(cmd_ready6),
        .cmd_write(1'b0), .wr_data(16'h0000), .wr_ack(wr_ack6),
        .dq_out(dq_out6), .dq_oe(dq_oe6), .dq_in(dq_in6),
        .rd_data(rd_data6), .rd_valid(rd_valid6), .busy(busy6)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic go(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- behavioural model (timestamps, not states) ----------
    int           m_idle_from = 0;     // first cycle the controller is idle
    int           m_wa_lo = -1, m_wa_hi = -2;   // write-ack window
    int           m_cap_lo = -1, m_cap_hi = -2; // dq_in capture window
    logic         m_oe = 1'b0, m_rv = 1'b0;
    logic [W-1:0] m_dq = '0, m_rd = '0;

    // Compare on every falling edge, then advance the model with this
    // cycle's inputs.
    always @(negedge clk) begin
        int   c;
        logic e_ready, e_busy, e_wack, cap;
        c       = cyc;
        e_ready = !reset && (c >= m_idle_from);
        e_busy  = (c < m_idle_from);
        e_wack  = !reset && ((e_ready && cmd_valid && cmd_write) ||
                             (c >= m_wa_lo && c <= m_wa_hi));
        cap     = !reset && (c >= m_cap_lo && c <= m_cap_hi);

        chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, e_ready});
        chk("busy",      {31'd0, busy},      {31'd0, e_busy});
        chk("wr_ack",    {31'd0, wr_ack},    {31'd0, e_wack});
        chk("dq_oe",     {31'd0, dq_oe},     {31'd0, m_oe});
        chk("dq_out",    {16'd0, dq_out},    {16'd0, m_dq});
        chk("rd_valid",  {31'd0, rd_valid},  {31'd0, m_rv});
        chk("rd_data",   {16'd0, rd_data},   {16'd0, m_rd});
        if (cap) chk("oe_during_capture", {31'd0, dq_oe}, 32'd0);

        if (reset) begin
            m_oe = 1'b0; m_dq = '0; m_rv = 1'b0; m_rd = '0;
            m_idle_from = c + 1;
            m_wa_lo = -1; m_wa_hi = -2; m_cap_lo = -1; m_cap_hi = -2;
        end else begin
            m_oe = e_wack;
            if (e_wack) m_dq = wr_data;
            m_rv = cap;
            if (cap) m_rd = dq_in;
            if (e_ready && cmd_valid) begin
                if (cmd_write) begin
                    m_wa_lo = c; m_wa_hi = c + BL - 1;
                    m_idle_from = c + BL + 1;
                end else begin
                    m_cap_lo = c + CL; m_cap_hi = c + CL + BL - 1;
                    m_idle_from = c + CL + BL + TA;
                end
            end
        end

        // Hand-computed literal expectations for the directed scenarios.
        case (c)
            1, 2: begin
                chk("rst_oe", {31'd0, dq_oe}, 32'd0);
                chk("rst_dq", {16'd0, dq_out}, 32'd0);
                chk("rst_rv", {31'd0, rd_valid}, 32'd0);
                chk("rst_busy", {31'd0, busy}, 32'd0);
                chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
            end
            3:  chk("rel_ready", {31'd0, cmd_ready}, 32'd1);
            11, 12, 13, 14: begin
                chk("s2_oe", {31'd0, dq_oe}, 32'd1);
                chk("s2_dq", {16'd0, dq_out}, 32'hA000 + 32'(c - 10));
            end
            15: begin
                chk("s2_oe_off", {31'd0, dq_oe}, 32'd0);
                chk("s2_ready", {31'd0, cmd_ready}, 32'd1);
                chk("s2_hold", {16'd0, dq_out}, 32'hA004);
            end
            27: begin
                chk("s4_ready", {31'd0, cmd_ready}, 32'd1);
                chk("s4_wack", {31'd0, wr_ack}, 32'd1);
            end
            28: begin
                chk("s4_oe", {31'd0, dq_oe}, 32'd1);
                chk("s4_dq", {16'd0, dq_out}, 32'hB001);
            end
            42: begin
                chk("s5_wack", {31'd0, wr_ack}, 32'd0);
                chk("s5_oe_pre", {31'd0, dq_oe}, 32'd1);
            end
            43: begin
                chk("s5_oe", {31'd0, dq_oe}, 32'd0);
                chk("s5_dq", {16'd0, dq_out}, 32'd0);
                chk("s5_wack_rst", {31'd0, wr_ack}, 32'd0);
            end
            44: begin
                chk("s5_ready", {31'd0, cmd_ready}, 32'd1);
                chk("s5_busy", {31'd0, busy}, 32'd0);
            end
            default: ;
        endcase
        if (c >= 22 && c <= 25) chk("s3_oe", {31'd0, dq_oe}, 32'd0);
        if (c >= 23 && c <= 26) begin
            chk("s3_rv", {31'd0, rd_valid}, 32'd1);
            chk("s3_rd", {16'd0, rd_data}, 32'h1111 * 32'(c - 22));
        end
        if (c == 26) begin
            chk("s3_turn_busy", {31'd0, busy}, 32'd1);
            chk("s3_turn_ready", {31'd0, cmd_ready}, 32'd0);
        end

        // Second instance: CL=3, BL=1, TA=0, read accepted at cycle 5.
        if (c >= 5 && c <= 10) begin
            chk("s6_oe", {31'd0, dq_oe6}, 32'd0);
            chk("s6_rv", {31'd0, rd_valid6}, (c == 9) ? 32'd1 : 32'd0);
            chk("s6_ready", {31'd0, cmd_ready6}, (c == 5 || c >= 9) ? 32'd1 : 32'd0);
        end
        if (c == 9 || c == 10) chk("s6_rd", {16'd0, rd_data6}, 32'hBEEF);
    end

    // Second-instance stimulus.
    initial begin
        cmd_valid6 = 1'b0;
        dq_in6     = 16'h0000;
        go(5);  cmd_valid6 = 1'b1;
        go(6);  cmd_valid6 = 1'b0;
        go(8);  dq_in6 = 16'hBEEF;
        go(9);  dq_in6 = 16'h0000;
    end

    // Main directed stimulus.
    initial begin
        logic [31:0] pat;
        pat       = 32'b1011_0010_0111_0100_1100_1001_0110_1010;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        wr_data   = '0;
        dq_in     = '0;
        go(3);  reset = 1'b0;
        // Scenario: write burst accepted at 10
        go(9);  wr_data = 16'hFFFF;
        go(10); cmd_valid = 1'b1; cmd_write = 1'b1; wr_data = 16'hA001;
        go(11); cmd_valid = 1'b0; wr_data = 16'hA002;
        go(12); wr_data = 16'hA003;
        go(13); wr_data = 16'hA004;
        go(14); wr_data = 16'hFFFF;
        // Scenario: read at 20, write held pending from 21
        go(20); cmd_valid = 1'b1; cmd_write = 1'b0; dq_in = 16'hDEAD;
        go(21); cmd_write = 1'b1;
        go(22); dq_in = 16'h1111;
        go(23); dq_in = 16'h2222;
        go(24); dq_in = 16'h3333;
        go(25); dq_in = 16'h4444;
        go(26); dq_in = 16'hDEAD;
        go(27); wr_data = 16'hB001;
        go(28); cmd_valid = 1'b0; wr_data = 16'hB002;
        go(29); wr_data = 16'hB003;
        go(30); wr_data = 16'hB004;
        go(31); wr_data = 16'hFFFF;
        // Scenario: reset during a write; command during reset ignored
        go(40); cmd_valid = 1'b1; cmd_write = 1'b1; wr_data = 16'hC001;
        go(41); cmd_valid = 1'b0; wr_data = 16'hC002;
        go(42); reset = 1'b1; wr_data = 16'hC003;
        go(43); cmd_valid = 1'b1;
        go(44); reset = 1'b0; cmd_valid = 1'b0;
        // Back-to-back commands with a mid-stream reset pulse
        for (int c = 50; c < 110; c++) begin
            go(c);
            cmd_valid = 1'b1;
            cmd_write = pat[c % 32];
            wr_data   = 16'h5000 + 16'(c);
            dq_in     = 16'h6000 + 16'(c);
            reset     = (c == 90);
        end
        go(110); cmd_valid = 1'b0; reset = 1'b0;
        go(130);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
